// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory: per-stage response
// record, byte geometry and parameter legality checks.
package dmem_pkg;

    localparam int BYTE_WIDTH       = 8;
    localparam int MAX_DATA_WIDTH   = 64;
    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;

    // The data field is sized for the widest supported word; narrower
    // instances zero-extend into it and read back only the low bits.
    typedef struct packed {
        logic                      valid;
        logic [MAX_DATA_WIDTH-1:0] data;
        logic                      write;
        logic                      error;
    } respStage_t;

    function automatic int byteCount(input int dataWidth);
        return dataWidth / BYTE_WIDTH;
    endfunction

    function automatic bit latencyLegal(input int readLatency);
        return (readLatency >= MIN_READ_LATENCY) && (readLatency <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte synchronous write and an asynchronous read port
// that the top level samples into its first pipeline stage.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1000,
    parameter int INIT_BASE  = 500,
    parameter int INIT_COUNT = 10
) (
    input  logic                             clk,
    input  logic                             wrEn,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH-1:0]            wrData,
    input  logic [byteCount(DATA_WIDTH)-1:0] byteEn,
    output logic [DATA_WIDTH-1:0]            rdData,
    output logic                             inRange
);

    localparam int NUM_BYTES = byteCount(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Time-zero contents expected by the existing test programs.
    initial begin
        for (int i = 0; i < INIT_COUNT; i++) begin
            mem[INIT_BASE + i] = DATA_WIDTH'(i + 1);
        end
    end

    assign inRange = ({1'b0, addr} < DEPTH_LIMIT);
    assign rdData  = inRange ? mem[addr] : '0;

    always_ff @(posedge clk) begin
        if (wrEn && inRange) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (byteEn[b]) begin
                    mem[addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wrData[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/pipelined_data_memory.sv
// Pipelined data memory: one request per cycle, in-order responses after
// READ_LATENCY cycles, byte-enable writes, range errors and backpressure.
module pipelined_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 1000,
    parameter int READ_LATENCY = 1,
    parameter int INIT_BASE    = 500,
    parameter int INIT_COUNT   = 10
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic                             reqValid,
    output logic                             reqReady,
    input  logic                             reqWrite,
    input  logic [ADDR_WIDTH-1:0]            reqAddr,
    input  logic [DATA_WIDTH-1:0]            reqWData,
    input  logic [byteCount(DATA_WIDTH)-1:0] reqByteEn,
    output logic                             respValid,
    input  logic                             respReady,
    output logic [DATA_WIDTH-1:0]            respData,
    output logic                             respWrite,
    output logic                             respError
);

    if (!latencyLegal(READ_LATENCY) || (DATA_WIDTH % BYTE_WIDTH) != 0 ||
        DATA_WIDTH > MAX_DATA_WIDTH || DEPTH > (2 ** ADDR_WIDTH)) begin : gBadParams
        $error("pipelined_data_memory: illegal parameter combination");
    end

    respStage_t            stages [READ_LATENCY];
    respStage_t            loadStage;
    respStage_t            outStage;
    logic                  advance;
    logic                  accept;
    logic                  inRange;
    logic [DATA_WIDTH-1:0] rdData;

    // Handshake: a request transfers on a cycle where reqValid && reqReady; a
    // response transfers where respValid && respReady. The whole pipeline
    // advances unless a valid response is waiting on a stalled consumer, and
    // reqReady mirrors that advance decision combinationally.
    assign outStage  = stages[READ_LATENCY-1];
    assign advance   = !(outStage.valid && !respReady);
    assign reqReady  = advance;
    assign accept    = reqValid && advance;

    assign respValid = outStage.valid;
    assign respData  = outStage.data[DATA_WIDTH-1:0];
    assign respWrite = outStage.write;
    assign respError = outStage.error;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .INIT_BASE  (INIT_BASE),
        .INIT_COUNT (INIT_COUNT)
    ) uArray (
        .clk     (clk),
        .wrEn    (accept && reqWrite),
        .addr    (reqAddr),
        .wrData  (reqWData),
        .byteEn  (reqByteEn),
        .rdData  (rdData),
        .inRange (inRange)
    );

    always_comb begin
        loadStage       = '0;
        loadStage.valid = accept;
        loadStage.write = accept && reqWrite;
        loadStage.error = accept && !inRange;
        if (accept && !reqWrite && inRange) begin
            loadStage.data = MAX_DATA_WIDTH'(rdData);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else if (advance) begin
            stages[0] <= loadStage;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Directed and scoreboarded checks of pipelined_data_memory at read latency 1
// (instance A) and read latency 3 (instance B).
module tb_pipelined_data_memory;

    logic clk;
    logic rstN;

    logic        aReqValid, aReqReady, aReqWrite;
    logic [9:0]  aReqAddr;
    logic [15:0] aReqWData;
    logic [1:0]  aReqByteEn;
    logic        aRespValid, aRespReady, aRespWrite, aRespError;
    logic [15:0] aRespData;

    logic        bReqValid, bReqReady, bReqWrite;
    logic [9:0]  bReqAddr;
    logic [15:0] bReqWData;
    logic [1:0]  bReqByteEn;
    logic        bRespValid, bRespReady, bRespWrite, bRespError;
    logic [15:0] bRespData;

    int compared   = 0;
    int mismatched = 0;

    logic [17:0] expQ [$];
    logic [15:0] refMem [0:1023];

    pipelined_data_memory #(.READ_LATENCY(1)) dutA (
        .clk(clk), .rstN(rstN),
        .reqValid(aReqValid), .reqReady(aReqReady), .reqWrite(aReqWrite),
        .reqAddr(aReqAddr), .reqWData(aReqWData), .reqByteEn(aReqByteEn),
        .respValid(aRespValid), .respReady(aRespReady), .respData(aRespData),
        .respWrite(aRespWrite), .respError(aRespError)
    );

    pipelined_data_memory #(.READ_LATENCY(3)) dutB (
        .clk(clk), .rstN(rstN),
        .reqValid(bReqValid), .reqReady(bReqReady), .reqWrite(bReqWrite),
        .reqAddr(bReqAddr), .reqWData(bReqWData), .reqByteEn(bReqByteEn),
        .respValid(bRespValid), .respReady(bRespReady), .respData(bRespData),
        .respWrite(bRespWrite), .respError(bRespError)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // drivers
    task automatic reqA(input logic wr, input logic [9:0] addr, input logic [15:0] wdata, input logic [1:0] be);
        aReqValid = 1'b1; aReqWrite = wr; aReqAddr = addr; aReqWData = wdata; aReqByteEn = be;
    endtask

    task automatic idleA();
        aReqValid = 1'b0; aReqWrite = 1'b0; aReqAddr = '0; aReqWData = '0; aReqByteEn = '0;
    endtask

    task automatic reqB(input logic wr, input logic [9:0] addr, input logic [15:0] wdata, input logic [1:0] be);
        bReqValid = 1'b1; bReqWrite = wr; bReqAddr = addr; bReqWData = wdata; bReqByteEn = be;
    endtask

    task automatic idleB();
        bReqValid = 1'b0; bReqWrite = 1'b0; bReqAddr = '0; bReqWData = '0; bReqByteEn = '0;
    endtask

    // scoreboard: reference model update on accept, compare on response transfer
    task automatic modelAccept();
        logic inR;
        inR = (aReqAddr < 10'd1000);
        if (aReqWrite) begin
            if (inR) begin
                if (aReqByteEn[0]) refMem[aReqAddr][7:0]  = aReqWData[7:0];
                if (aReqByteEn[1]) refMem[aReqAddr][15:8] = aReqWData[15:8];
            end
            expQ.push_back({!inR, 1'b1, 16'h0000});
        end else begin
            expQ.push_back({!inR, 1'b0, inR ? refMem[aReqAddr] : 16'h0000});
        end
    endtask

    task automatic popCheck();
        if (expQ.size() == 0) begin
            check("rand_extra_resp", 32'(aRespValid), 32'd0);
        end else begin
            check("rand_resp", 32'({aRespError, aRespWrite, aRespData}), 32'(expQ.pop_front()));
        end
    endtask

    initial begin
        int accepted;
        int cyc;
        int pick;

        for (int i = 0; i < 1024; i++) refMem[i] = 16'h0000;
        for (int i = 0; i < 10; i++) refMem[500 + i] = 16'(i + 1);

        rstN = 1'b0;
        idleA(); idleB();
        aRespReady = 1'b1;
        bRespReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        check("rst_respValid", 32'(aRespValid), 32'd0);
        check("rst_respData",  32'(aRespData),  32'd0);
        check("rst_respWrite", 32'(aRespWrite), 32'd0);
        check("rst_respError", 32'(aRespError), 32'd0);
        check("rst_b_respValid", 32'(bRespValid), 32'd0);
        rstN = 1'b1;
        #1;
        check("rst_reqReady", 32'(aReqReady), 32'd1);
        tick();

        // back-to-back preload reads, latency 1
        reqA(1'b0, 10'd500, 16'h0, 2'b00); tick();
        check("t1_valid0", 32'(aRespValid), 32'd1);
        check("t1_data0",  32'(aRespData),  32'd1);
        reqA(1'b0, 10'd501, 16'h0, 2'b00); tick();
        check("t1_data1",  32'(aRespData),  32'd2);
        reqA(1'b0, 10'd509, 16'h0, 2'b00); tick();
        check("t1_data2",  32'(aRespData),  32'd10);
        check("t1_error",  32'(aRespError), 32'd0);
        idleA(); tick();
        check("t1_bubble", 32'(aRespValid), 32'd0);

        // byte-enable writes then read-after-write
        reqA(1'b1, 10'd20, 16'hABCD, 2'b11); tick();
        check("t2_ack0", 32'({aRespValid, aRespWrite, aRespData}), 32'h3_0000);
        reqA(1'b1, 10'd20, 16'h0012, 2'b01); tick();
        check("t2_ack1", 32'({aRespValid, aRespWrite, aRespData}), 32'h3_0000);
        reqA(1'b0, 10'd20, 16'h0, 2'b00); tick();
        check("t2_rd_data",  32'(aRespData),  32'hAB12);
        check("t2_rd_write", 32'(aRespWrite), 32'd0);
        reqA(1'b1, 10'd20, 16'hFFFF, 2'b00); tick();
        check("t2_be0_ack", 32'({aRespValid, aRespWrite}), 32'h3);
        reqA(1'b0, 10'd20, 16'h0, 2'b00); tick();
        check("t2_be0_data", 32'(aRespData), 32'hAB12);

        // out-of-range accesses
        reqA(1'b0, 10'd1000, 16'h0, 2'b00); tick();
        check("t4_rd_err",  32'({aRespValid, aRespError, aRespData}), 32'h3_0000);
        reqA(1'b1, 10'd1023, 16'hFFFF, 2'b11); tick();
        check("t4_wr_err",  32'({aRespError, aRespWrite, aRespData}), 32'h3_0000);
        reqA(1'b1, 10'd999, 16'h1234, 2'b11); tick();
        check("t4_wr999_err", 32'(aRespError), 32'd0);
        reqA(1'b0, 10'd999, 16'h0, 2'b00); tick();
        check("t4_rd999", 32'({aRespError, aRespData}), 32'h0_1234);
        idleA(); tick();

        // latency 3 with response backpressure
        reqB(1'b0, 10'd502, 16'h0, 2'b00); tick();
        reqB(1'b0, 10'd503, 16'h0, 2'b00); tick();
        idleB();
        bRespReady = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t3_stall_valid", 32'(bRespValid), 32'd1);
            check("t3_stall_data",  32'(bRespData),  32'd3);
            check("t3_stall_ready", 32'(bReqReady),  32'd0);
            tick();
        end
        bRespReady = 1'b1;
        #1;
        check("t3_release_data",  32'(bRespData), 32'd3);
        check("t3_release_ready", 32'(bReqReady), 32'd1);
        tick();
        check("t3_second", 32'({bRespValid, bRespData}), 32'h1_0004);
        tick();
        check("t3_drained", 32'(bRespValid), 32'd0);

        // reset with responses in flight
        reqB(1'b1, 10'd30, 16'h5555, 2'b11); tick();
        reqB(1'b0, 10'd501, 16'h0, 2'b00); tick();
        reqB(1'b0, 10'd502, 16'h0, 2'b00); tick();
        idleB();
        check("t5_pre_ack", 32'({bRespValid, bRespWrite}), 32'h3);
        #2;
        rstN = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bRespValid), 32'd0);
        @(posedge clk);
        #3;
        rstN = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_no_stale", 32'(bRespValid), 32'd0);
            tick();
        end
        reqB(1'b0, 10'd30, 16'h0, 2'b00); tick();
        idleB(); tick(); tick();
        check("t5_write_kept", 32'({bRespValid, bRespWrite, bRespData}), 32'h2_5555);
        tick();

        // random mix against the reference model
        for (int i = 0; i < 16; i++) begin
            reqA(1'b1, 10'(i), 16'(i * 16'h1111), 2'b11);
            refMem[i] = 16'(i * 16'h1111);
            tick();
        end
        idleA(); tick();

        accepted = 0;
        cyc = 0;
        while (accepted < 200 && cyc < 3000) begin
            aReqValid  = ($urandom_range(0, 3) != 0);
            aReqWrite  = 1'($urandom_range(0, 1));
            pick       = $urandom_range(0, 2);
            if (pick == 0)      aReqAddr = 10'($urandom_range(0, 15));
            else if (pick == 1) aReqAddr = 10'($urandom_range(500, 509));
            else                aReqAddr = 10'($urandom_range(1000, 1003));
            aReqWData  = 16'($urandom);
            aReqByteEn = 2'($urandom_range(0, 3));
            aRespReady = ($urandom_range(0, 3) != 0);
            #1;
            if (aRespValid && aRespReady) popCheck();
            if (aReqValid && aReqReady) begin
                modelAccept();
                accepted++;
            end
            tick();
            cyc++;
        end
        check("rand_accepted", 32'(accepted), 32'd200);
        idleA();
        aRespReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (aRespValid) popCheck();
            tick();
        end
        check("rand_queue_empty", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
